draw_dstrd_ctrl: RTL
====================

// Module: draw_dstrd_ctrl
// PURPOSE
//  Sequences destination-pixel readback from VRAM into the draw destination buffer (64-bit, 512-deep FIFO).
//  Splits a START command into burst read requests on the VRAM interface. Issues a burst only when FIFO
//  credits cover it, so the buffer never overflows. Drives the buffer's DSTSEL/INIT and reports BUSY/DONE.
// PARAMETERS
//  ADDR_W      32   VRAM byte-address width
//  CNT_W       16   width of command word count (64-bit words)
//  BURST       16   max words per VRAM read request (1..255)
//  FIFO_DEPTH  512  destination buffer depth in words; credit pool size
// PORTS
//  CLK              in   1       clock, all logic on rising edge
//  RST              in   1       synchronous reset, active-high
//  START            in   1       command strobe; sampled only in IDLE
//  START_ADDR       in   ADDR_W  first VRAM byte address (8-byte aligned)
//  WORD_CNT         in   CNT_W   number of 64-bit words to read
//  VIF_RREQ         out  1       read request valid; held until VIF_RACK
//  VIF_RADDR        out  ADDR_W  request byte address
//  VIF_RLEN         out  8       request length in words (1..BURST)
//  VIF_RACK         in   1       request accepted this cycle
//  VIF_DRWRDATAVLD  in   1       one read word returning from VRAM
//  BUF_RD           in   1       consumer pop of destination buffer (frees one credit)
//  DSTSEL           out  1       routes returning VRAM data into destination buffer
//  INIT             out  1       1-cycle buffer clear pulse at command start
//  BUSY             out  1       high from START acceptance until DONE
//  DONE             out  1       1-cycle pulse: all words requested and returned
//  ERR              out  1       sticky: data returned with none outstanding; cleared on accepted START
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. RST mid-operation aborts immediately; no DONE is issued.
//  States: IDLE -> CLR -> REQ <-> WACK -> DRAIN -> FIN -> IDLE.
//   IDLE : START=1 latches addr/count, clears ERR, BUSY=1 next cycle, -> CLR.
//   CLR  : INIT=1 for exactly this cycle; credits_used:=0; -> REQ if count>0, else -> FIN.
//   REQ  : len=min(BURST,remaining). If FIFO_DEPTH-credits_used >= len, assert VIF_RREQ/RADDR/RLEN
//          and -> WACK; else stay in REQ (stall; no request is driven).
//   WACK : hold RREQ/RADDR/RLEN stable. On RACK: credits_used+=len, outstanding+=len, addr+=len*8,
//          remaining-=len; -> REQ if remaining>0, else -> DRAIN.
//   DRAIN: wait outstanding==0 -> FIN.
//   FIN  : DONE=1 one cycle, BUSY=0 next cycle, -> IDLE. DSTSEL stays 1 through FIN.
//  DSTSEL=1 in CLR..FIN, 0 in IDLE. The buffer registers data and DSTSEL together, so data returned in the
//   FIN cycle is still captured.
//  outstanding (CNT_W+1 bits): -1 per VIF_DRWRDATAVLD while BUSY. Same-cycle RACK and VLD nets +len-1.
//   VLD with outstanding==0, or VLD in IDLE: ignored, ERR:=1.
//  credits_used (log2(FIFO_DEPTH)+1 bits): -1 per BUF_RD when >0; BUF_RD at 0 is ignored.
//   Same-cycle RACK and BUF_RD nets +len-1. BUF_RD is counted in every state except CLR,
//   including IDLE for post-DONE drain.
//  Invariant: credits_used <= FIFO_DEPTH at all times; a request never exceeds the free credits.
//  START while BUSY is ignored. WORD_CNT=0 gives INIT, then a DONE pulse 2 cycles after START, no request.
//  Address arithmetic wraps modulo 2^ADDR_W; no boundary splitting is done.
// TESTING
//  1 START addr=0x1000 cnt=40, RACK next cycle, BUF_RD always 1 -> 3 reqs (0x1000/16, 0x1080/16,
//    0x1100/8); DONE one cycle after last VLD's DRAIN exit.
//  2 cnt=600, BUF_RD=0 -> requests stop at 512 credits (32 bursts), RREQ low; pulse BUF_RD 16x ->
//    next burst issues; no overflow at any point.
//  3 Same-cycle RACK+VLD and RACK+BUF_RD -> counters net len-1; DONE still after exactly cnt VLDs.
//  4 VLD in IDLE -> ERR=1; next START -> ERR=0. START while BUSY -> no effect on addr/count.
//  5 cnt=0 -> INIT pulse, DONE 2 cycles after START, VIF_RREQ never asserted.
//  6 RST asserted in WACK -> next cycle all outputs 0, state IDLE; new START runs cleanly.

Source files
------------

// File: rtl/draw_dstrd_ctrl.sv
// Destination-pixel readback sequencer: splits a START command into credit-gated
// VRAM burst reads that fill the draw destination buffer, and reports BUSY/DONE/ERR.
module draw_dstrd_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 512
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [CNT_W-1:0]  WORD_CNT,
  output logic              VIF_RREQ,
  output logic [ADDR_W-1:0] VIF_RADDR,
  output logic [7:0]        VIF_RLEN,
  input  logic              VIF_RACK,
  input  logic              VIF_DRWRDATAVLD,
  input  logic              BUF_RD,
  output logic              DSTSEL,
  output logic              INIT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [2:0]        dbg_state
);

  localparam int CR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_REQ   = 3'd2,
    S_WACK  = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [CR_W-1:0]   cr_q, cr_d;
  logic              err_q, err_d;
  logic              rreq_q, rreq_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rlen_q, rlen_d;
  logic              dstsel_q, dstsel_d;
  logic              init_q, init_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        len;
  logic [CR_W-1:0]   free_cr;
  logic              rack_fire;
  logic              vld_ok;

  always_comb begin
    if (rem_q > CNT_W'(BURST)) len = 8'(BURST);
    else                       len = 8'(rem_q);
    free_cr   = CR_W'(FIFO_DEPTH) - cr_q;
    rack_fire = (state_q == S_WACK) && VIF_RACK;
    // Returning data is only legal while a command is active and words are owed.
    vld_ok    = VIF_DRWRDATAVLD && (state_q != S_IDLE) && (out_q != '0);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    out_d   = out_q + (rack_fire ? OUT_W'(len) : '0) - (vld_ok ? OUT_W'(1) : '0);
    cr_d    = cr_q + (rack_fire ? CR_W'(len) : '0)
                   - ((BUF_RD && (cr_q != '0)) ? CR_W'(1) : '0);
    err_d   = err_q | (VIF_DRWRDATAVLD && !vld_ok);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLR;
          addr_d  = START_ADDR;
          rem_d   = WORD_CNT;
          err_d   = 1'b0;
        end
      end
      S_CLR: begin
        cr_d    = '0;
        state_d = (rem_q != '0) ? S_REQ : S_FIN;
      end
      S_REQ: begin
        if (free_cr >= CR_W'(len)) state_d = S_WACK;
      end
      S_WACK: begin
        if (VIF_RACK) begin
          addr_d  = addr_q + ADDR_W'({len, 3'b000});
          rem_d   = rem_q - CNT_W'(len);
          state_d = (rem_d != '0) ? S_REQ : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rreq_d   = (state_d == S_WACK);
    raddr_d  = (state_d == S_WACK) ? addr_q : '0;
    rlen_d   = (state_d == S_WACK) ? len : '0;
    dstsel_d = (state_d != S_IDLE);
    busy_d   = (state_d != S_IDLE);
    init_d   = (state_d == S_CLR);
    done_d   = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      out_q    <= '0;
      cr_q     <= '0;
      err_q    <= 1'b0;
      rreq_q   <= 1'b0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      dstsel_q <= 1'b0;
      init_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      cr_q     <= cr_d;
      err_q    <= err_d;
      rreq_q   <= rreq_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      dstsel_q <= dstsel_d;
      init_q   <= init_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign VIF_RREQ  = rreq_q;
  assign VIF_RADDR = raddr_q;
  assign VIF_RLEN  = rlen_q;
  assign DSTSEL    = dstsel_q;
  assign INIT      = init_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign dbg_state = state_q;

endmodule
